// File: rtl/system_clkgen.sv
// system_clkgen: NUM_CLKS programmable divided clocks with duty/phase control and a lock sequencer.
// Define SYSTEM_CLKGEN_GATE_EN to add per-channel glitch-free clk_gate inputs.
module system_clkgen #(
  parameter int NUM_CLKS    = 2,
  parameter int CNT_W       = 8,
  parameter int SEL_W       = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_phase,
`ifdef SYSTEM_CLKGEN_GATE_EN
  input  logic [NUM_CLKS-1:0] clk_gate,
`endif
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic                locked
);

  localparam int                SETTLE_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]    NUM_SEL  = (SEL_W + 1)'(NUM_CLKS);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    S_RESET,
    S_SETTLE,
    S_LOCKED,
    S_APPLY
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_restart;
  logic                 w_write;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_locked;

  assign cfg_ready = (r_state == S_SETTLE) || (r_state == S_LOCKED);
  // Out-of-range selects complete the handshake but never reach the FSM.
  assign w_write   = cfg_valid && cfg_ready && ({1'b0, cfg_sel} < NUM_SEL);
  assign locked    = r_locked;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_settle <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
      if (w_restart)
        r_settle <= '0;
      else if ((r_state == S_SETTLE) && (r_settle != SETTLE_LAST))
        r_settle <= r_settle + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state_nxt = S_SETTLE;
        w_restart   = 1'b1;
      end
      S_SETTLE: begin
        if (w_write)
          w_state_nxt = S_APPLY;
        else if (r_settle == SETTLE_LAST)
          w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (w_write)
          w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_state_nxt = S_SETTLE;
        w_restart   = 1'b1;
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

    logic [CNT_W-1:0] r_sh_div;
    logic [CNT_W-1:0] r_sh_high;
    logic [CNT_W-1:0] r_sh_phase;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dly;
    logic             r_out;
    logic             r_en;
    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] w_high;
    logic [CNT_W-1:0] w_phase;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_dly_nxt;
    logic             w_out_nxt;

    // Shadow fields are stored raw and only made legal when loaded into the counters.
    always_comb begin
      w_div   = (r_sh_div < TWO) ? TWO : r_sh_div;
      w_high  = (r_sh_high == '0) ? (w_div >> 1) : r_sh_high;
      if (w_high >= w_div)
        w_high = w_div - ONE;
      w_phase = (r_sh_phase >= w_div) ? (w_div - ONE) : r_sh_phase;
    end

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_dly_nxt = r_dly;
      w_out_nxt = 1'b0;
      if (r_dly != '0) begin
        w_dly_nxt = r_dly - ONE;
      end else begin
        w_out_nxt = (r_cnt < r_high);
        w_cnt_nxt = (r_cnt == (r_div - ONE)) ? '0 : (r_cnt + ONE);
`ifdef SYSTEM_CLKGEN_GATE_EN
        // A gated channel finishes its current high phase, then parks at cnt 0.
        if (!clk_gate[i] && !(r_out && w_out_nxt)) begin
          w_out_nxt = 1'b0;
          w_cnt_nxt = '0;
        end
`endif
      end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh_div   <= DIV_RST;
        r_sh_high  <= '0;
        r_sh_phase <= '0;
        r_div      <= TWO;
        r_high     <= ONE;
        r_cnt      <= '0;
        r_dly      <= '0;
        r_out      <= 1'b0;
        r_en       <= 1'b0;
      end else begin
        if (w_write && (cfg_sel == IDX)) begin
          r_sh_div   <= cfg_div;
          r_sh_high  <= cfg_high;
          r_sh_phase <= cfg_phase;
        end
        if (w_restart) begin
          r_div  <= w_div;
          r_high <= w_high;
          r_cnt  <= '0;
          r_dly  <= w_phase;
          r_out  <= 1'b0;
          r_en   <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_dly  <= w_dly_nxt;
          r_out  <= w_out_nxt;
          r_en   <= w_out_nxt & ~r_out;
        end
      end
    end

    assign outclk[i]    = r_out;
    assign outclk_en[i] = r_en;
  end

endmodule

// File: tb/tb_system_clkgen.sv
// Scoreboard bench for system_clkgen: closed-form expected waveforms queued per edge, popped after each edge.
// Gating checks are compiled in when SYSTEM_CLKGEN_GATE_EN is defined.
module tb_system_clkgen;

  localparam int N    = 2;
  localparam int CW   = 8;
  localparam int SW   = 4;
  localparam int LOCK = 16;
  localparam int DDEF = 2;

  typedef struct {
    logic [N-1:0] out;
    logic [N-1:0] en;
    logic         lk;
    logic         rdy;
  } exp_t;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_sel;
  logic [CW-1:0] cfg_div;
  logic [CW-1:0] cfg_high;
  logic [CW-1:0] cfg_phase;
  logic [N-1:0]  outclk;
  logic [N-1:0]  outclk_en;
  logic          locked;
`ifdef SYSTEM_CLKGEN_GATE_EN
  logic [N-1:0]  clk_gate = '1;
`endif

  system_clkgen #(
    .NUM_CLKS(N), .CNT_W(CW), .SEL_W(SW), .LOCK_CYCLES(LOCK), .DIV_DEFAULT(DDEF)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .cfg_phase(cfg_phase),
`ifdef SYSTEM_CLKGEN_GATE_EN
    .clk_gate(clk_gate),
`endif
    .outclk(outclk),
    .outclk_en(outclk_en),
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  int   rs    = 0;
  int   lock_e = 0;
  int   m_div  [N];
  int   m_high [N];
  int   m_ph   [N];
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  function automatic void san(input int d, input int h, input int p,
                              output int od, output int oh, output int op);
    od = (d < 2) ? 2 : d;
    oh = (h == 0) ? od / 2 : h;
    if (oh >= od) oh = od - 1;
    op = (p >= od) ? od - 1 : p;
  endfunction

  function automatic exp_t predict(input int e);
    exp_t x;
    int   t;
    x.out = '0;
    x.en  = '0;
    for (int c = 0; c < N; c++) begin
      t = e - rs - 1 - m_ph[c];
      if (t >= 0) begin
        x.out[c] = ((t % m_div[c]) < m_high[c]);
        x.en[c]  = ((t % m_div[c]) == 0);
      end
    end
    x.lk  = (e >= lock_e);
    x.rdy = (e >= rs);
    return x;
  endfunction

  task automatic tick();
    exp_t x;
    @(posedge refclk);
    n++;
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("outclk", 32'(outclk), 32'(x.out));
      chk("outclk_en", 32'(outclk_en), 32'(x.en));
      chk("locked", 32'(locked), 32'(x.lk));
      chk("cfg_ready", 32'(cfg_ready), 32'(x.rdy));
    end
  endtask

  task automatic run(input int k);
    repeat (k) begin
      sb.push_back(predict(n + 1));
      tick();
    end
  endtask

  task automatic model_defaults();
    for (int c = 0; c < N; c++) san(DDEF, 0, 0, m_div[c], m_high[c], m_ph[c]);
    rs     = n + 1;
    lock_e = rs + LOCK;
  endtask

  task automatic cfg_write(input int sel, input int d, input int h, input int p);
    exp_t x;
    bit   ok;
    ok = (sel < N);
    chk("ready_before_write", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_sel   = SW'(sel);
    cfg_div   = CW'(d);
    cfg_high  = CW'(h);
    cfg_phase = CW'(p);
    // Acceptance edge still shows the old waveforms.
    x = predict(n + 1);
    if (ok) begin
      x.lk  = 1'b0;
      x.rdy = 1'b0;
    end
    sb.push_back(x);
    tick();
    cfg_valid = 1'b0;
    if (ok) begin
      san(d, h, p, m_div[sel], m_high[sel], m_ph[sel]);
      rs     = n + 1;
      lock_e = rs + LOCK;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_en", 32'(outclk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    model_defaults();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = '0;
    cfg_div   = '0;
    cfg_high  = '0;
    cfg_phase = '0;
    tick();
    tick();
    chk("init_outclk", 32'(outclk), 32'd0);
    chk("init_en", 32'(outclk_en), 32'd0);
    chk("init_locked", 32'(locked), 32'd0);
    chk("init_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    model_defaults();
    run(24);

    cfg_write(1, 5, 0, 2);
    run(24);

    cfg_write(15, 3, 3, 3);
    run(6);

    cfg_write(0, 0, 0, 0);
    run(8);
    cfg_write(1, 4, 9, 0);
    run(10);
    cfg_write(0, 4, 0, 7);
    run(20);

    cfg_write(1, 7, 0, 0);
    run(4);
    do_reset();
    run(10);

    cfg_write(0, 3, 0, 1);
    do_reset();
    run(20);

`ifdef SYSTEM_CLKGEN_GATE_EN
    cfg_write(0, 6, 3, 0);
    tick();
    tick();
    tick();
    chk("gate_pre_high", 32'(outclk[0]), 32'd1);
    clk_gate[0] = 1'b0;
    tick();
    chk("gate_finish_high", 32'(outclk[0]), 32'd1);
    repeat (5) begin
      tick();
      chk("gate_hold_low", 32'(outclk[0]), 32'd0);
      chk("gate_no_en", 32'(outclk_en[0]), 32'd0);
    end
    clk_gate[0] = 1'b1;
    tick();
    chk("gate_resume", 32'(outclk[0]), 32'd1);
    chk("gate_resume_en", 32'(outclk_en[0]), 32'd1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
